// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for hazard detection and the mult/div unit.
// Register index width, $zero index, HI/LO occupancy states and latency.
package hazard_stall_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam int MD_LATENCY_DEF = 32;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_occupancy_counter.sv
// Tracks how long the mult/div unit holds HI/LO after an accepted issue.
// md_busy is high for exactly MD_LATENCY cycles following the accept edge.
module md_occupancy_counter
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    output logic md_busy
);

    localparam int CW = $clog2(MD_LATENCY + 1);

    md_state_t state_q;
    md_state_t state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    cnt_d   = CW'(MD_LATENCY);
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                // Count runs regardless of pipeline stalls.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = MD_IDLE;
                end
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use, HI/LO occupancy and branch-flush control beside the ID stage.
// Stall and flush outputs are purely combinational from inputs and state.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic             ID_is_md,
    input  logic             ID_uses_hilo,
    input  logic             ID_branch_taken,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_rt,
    output logic             Block_PC_Write,
    output logic             Block_IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic load_hz;
    logic md_hz;
    logic stall;
    logic md_accept;

    assign load_hz = EX_MemRead && (EX_rt != REG_ZERO) &&
                     ((EX_rt == ID_rs) ||
                      (ID_uses_rt && (EX_rt == ID_rt)));

    assign md_hz = md_busy && (ID_uses_hilo || ID_is_md);
    assign stall = load_hz || md_hz;

    assign Block_PC_Write    = stall;
    assign Block_IF_ID_Write = stall;
    assign ID_EX_Bubble      = stall;
    // A stalled branch is re-evaluated once the hazard clears.
    assign IF_ID_Flush       = ID_branch_taken && !stall;
    assign md_accept         = ID_is_md && !stall;

    md_occupancy_counter #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_occupancy_counter (
        .clk    (clk),
        .reset  (reset),
        .accept (md_accept),
        .md_busy(md_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and random checks of hazard_stall_unit against a cycle model.
module tb_hazard_stall_unit;

    localparam int LAT   = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ID_rs;
    logic [4:0]    ID_rt;
    logic          ID_uses_rt;
    logic          ID_is_md;
    logic          ID_uses_hilo;
    logic          ID_branch_taken;
    logic          EX_MemRead;
    logic [4:0]    EX_rt;
    logic          Block_PC_Write;
    logic          Block_IF_ID_Write;
    logic          ID_EX_Bubble;
    logic          IF_ID_Flush;
    logic          md_busy;
    logic [CW-1:0] stall_cycles;

    int errs   = 0;
    int checks = 0;
    int m_rem  = 0;
    int m_cnt  = 0;
    int snap;

    hazard_stall_unit #(
        .MD_LATENCY(LAT),
        .CNT_W     (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ID_rs            (ID_rs),
        .ID_rt            (ID_rt),
        .ID_uses_rt       (ID_uses_rt),
        .ID_is_md         (ID_is_md),
        .ID_uses_hilo     (ID_uses_hilo),
        .ID_branch_taken  (ID_branch_taken),
        .EX_MemRead       (EX_MemRead),
        .EX_rt            (EX_rt),
        .Block_PC_Write   (Block_PC_Write),
        .Block_IF_ID_Write(Block_IF_ID_Write),
        .ID_EX_Bubble     (ID_EX_Bubble),
        .IF_ID_Flush      (IF_ID_Flush),
        .md_busy          (md_busy),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; ID_is_md = 0;
        ID_uses_hilo = 0; ID_branch_taken = 0;
        EX_MemRead = 0; EX_rt = 0;
    endtask

    // One cycle: check current outputs, then advance model across the edge.
    task automatic tick();
        bit ld, mh, st, busy;
        busy = (m_rem > 0);
        ld = EX_MemRead && (EX_rt != 0) &&
             (EX_rt == ID_rs || (ID_uses_rt && EX_rt == ID_rt));
        mh = busy && (ID_uses_hilo || ID_is_md);
        st = ld || mh;
        #1;
        check("pc_block", 32'(Block_PC_Write), 32'(st));
        check("ifid_block", 32'(Block_IF_ID_Write), 32'(st));
        check("bubble", 32'(ID_EX_Bubble), 32'(st));
        check("flush", 32'(IF_ID_Flush), 32'(ID_branch_taken && !st));
        check("md_busy", 32'(md_busy), 32'(busy));
        check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        @(posedge clk);
        if (m_rem > 0) m_rem--;
        else if (ID_is_md && !st) m_rem = LAT;
        if (st && m_cnt < SAT) m_cnt++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_md_busy", 32'(md_busy), 0);
        check("rst_stall_cycles", 32'(stall_cycles), 0);
        m_rem = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #2;
        check("rst_pc_block", 32'(Block_PC_Write), 0);
        check("rst_flush", 32'(IF_ID_Flush), 0);
        check("rst_busy", 32'(md_busy), 0);
        check("rst_cnt", 32'(stall_cycles), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Load-use on rs: one stall cycle then clear.
        EX_MemRead = 1; EX_rt = 8; ID_rs = 8;
        tick();
        idle_inputs();
        tick();
        check("loaduse_cnt", 32'(stall_cycles), 1);

        // $zero destination and unused rt never stall.
        EX_MemRead = 1; EX_rt = 0; ID_rs = 0;
        tick();
        EX_rt = 9; ID_rt = 9; ID_uses_rt = 0; ID_rs = 3;
        tick();
        ID_uses_rt = 1;
        tick();
        idle_inputs();
        tick();

        // Mult then HI/LO consumer: consumer waits LAT-1 cycles.
        snap = m_cnt;
        ID_is_md = 1;
        tick();
        idle_inputs();
        tick();
        ID_uses_hilo = 1;
        for (int i = 0; i < LAT; i++) tick();
        check("mflo_stalls", 32'(stall_cycles), 32'(snap + LAT - 1));
        idle_inputs();
        tick();

        // Back-to-back mult: second issue waits for md_busy to fall.
        ID_is_md = 1;
        for (int i = 0; i < LAT + 2; i++) tick();
        idle_inputs();
        check("b2b_busy", 32'(md_busy), 1);
        for (int i = 0; i < LAT; i++) tick();
        check("b2b_done", 32'(md_busy), 0);

        // Branch under a load-use stall is held, then taken.
        EX_MemRead = 1; EX_rt = 5; ID_rs = 5; ID_branch_taken = 1;
        tick();
        EX_MemRead = 0;
        tick();
        idle_inputs();
        tick();

        // Reset in the middle of a busy window.
        ID_is_md = 1;
        tick();
        idle_inputs();
        tick();
        #2;
        do_reset();
        tick();

        // Counter saturation.
        EX_MemRead = 1; EX_rt = 7; ID_rs = 7;
        for (int i = 0; i < 20; i++) tick();
        check("saturate", 32'(stall_cycles), SAT);
        idle_inputs();
        tick();
        do_reset();

        for (int i = 0; i < 400; i++) begin
            ID_rs           = 5'($urandom_range(0, 3));
            ID_rt           = 5'($urandom_range(0, 3));
            ID_uses_rt      = 1'($urandom_range(0, 1));
            ID_is_md        = ($urandom_range(0, 5) == 0);
            ID_uses_hilo    = ($urandom_range(0, 3) == 0);
            ID_branch_taken = ($urandom_range(0, 3) == 0);
            EX_MemRead      = ($urandom_range(0, 2) == 0);
            EX_rt           = 5'($urandom_range(0, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
